// File: rtl/dec_to_frac_if.sv
// Request/result bundle for dec_to_frac: start strobe, seven BCD digits in,
// binary fraction with busy/done/error status out.
interface dec_to_frac_if #(
  parameter int width_z = 18
);
  localparam int FW = width_z - 3;

  logic          iStart;
  logic [3:0]    d0;
  logic [3:0]    d1;
  logic [3:0]    d2;
  logic [3:0]    d3;
  logic [3:0]    d4;
  logic [3:0]    d5;
  logic [3:0]    d6;
  logic [FW-1:0] oZ;
  logic          oBusy;
  logic          oDone;
  logic          oErr;

  modport master (
    output iStart, d0, d1, d2, d3, d4, d5, d6,
    input  oZ, oBusy, oDone, oErr
  );

  modport slave (
    input  iStart, d0, d1, d2, d3, d4, d5, d6,
    output oZ, oBusy, oDone, oErr
  );
endinterface

// File: rtl/dec_to_frac.sv
// BCD fraction 0.d0..d6 to unsigned binary fraction by Horner evaluation with a
// bit-serial restoring divide by ten. Optional rounding: DEC_TO_FRAC_ROUND_EN.
module dec_to_frac #(
  parameter int width_z  = 18,
  parameter int width_xy = 18
) (
  input logic           iCLK,
  input logic           iRST_N,
  dec_to_frac_if.slave  bus
);
  localparam int FW = width_z - 3;
  localparam int NW = FW + 4;
  localparam int CW = $clog2(NW);

  if (width_xy < 2 || width_z < 5) begin : g_param_chk
    $error("dec_to_frac: width_z must be >= 5 and width_xy >= 2");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  logic [27:0]   r_dig;
  logic [FW-1:0] r_acc;
  logic [2:0]    r_k;
  logic [NW-1:0] r_num;
  logic [3:0]    r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_err_pend;
  logic [FW-1:0] r_z;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic          w_in_bad;
  logic [3:0]    w_digit;
  logic [4:0]    w_trial;
  logic          w_ge;
  logic [3:0]    w_rem_nxt;
  logic [FW-1:0] w_quo;
  logic [FW-1:0] w_acc_nxt;

  function automatic logic [3:0] dig_sel(input logic [27:0] dig, input logic [2:0] k);
    logic [3:0] d;
    case (k)
      3'd0:    d = dig[27:24];
      3'd1:    d = dig[23:20];
      3'd2:    d = dig[19:16];
      3'd3:    d = dig[15:12];
      3'd4:    d = dig[11:8];
      3'd5:    d = dig[7:4];
      3'd6:    d = dig[3:0];
      default: d = 4'd0;
    endcase
    return d;
  endfunction

  function automatic logic [FW-1:0] sat_inc(input logic [FW-1:0] q);
    logic [FW-1:0] r;
    if (&q) begin
      r = q;
    end else begin
      r = q + FW'(1);
    end
    return r;
  endfunction

  // Digit validity at the sampling edge, current digit and one divide step.
  always_comb begin
    w_in_bad  = (bus.d0 > 4'd9) || (bus.d1 > 4'd9) || (bus.d2 > 4'd9) ||
                (bus.d3 > 4'd9) || (bus.d4 > 4'd9) || (bus.d5 > 4'd9) ||
                (bus.d6 > 4'd9);
    w_digit   = dig_sel(r_dig, r_k);
    w_trial   = {r_rem, r_num[NW-1]};
    w_ge      = (w_trial >= 5'd10);
    w_rem_nxt = 4'd0;
    if (w_ge) begin
      w_rem_nxt = 4'(w_trial - 5'd10);
    end else begin
      w_rem_nxt = w_trial[3:0];
    end
    // Quotient bits accumulate at the bottom of r_num; only the low FW survive.
    w_quo     = {r_num[FW-2:0], w_ge};
`ifdef DEC_TO_FRAC_ROUND_EN
    if (w_rem_nxt >= 4'd5) begin
      w_acc_nxt = sat_inc(w_quo);
    end else begin
      w_acc_nxt = w_quo;
    end
`else
    w_acc_nxt = w_quo;
`endif
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state    <= S_IDLE;
      r_dig      <= 28'd0;
      r_acc      <= '0;
      r_k        <= 3'd6;
      r_num      <= '0;
      r_rem      <= 4'd0;
      r_cnt      <= '0;
      r_err_pend <= 1'b0;
      r_z        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // A start coinciding with the done pulse is dropped.
          if (bus.iStart && !r_done) begin
            r_dig  <= {bus.d0, bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6};
            r_busy <= 1'b1;
            if (w_in_bad) begin
              r_err_pend <= 1'b1;
              r_state    <= S_DONE;
            end else begin
              r_err_pend <= 1'b0;
              r_acc      <= '0;
              r_k        <= 3'd6;
              r_state    <= S_LOAD;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_LOAD: begin
          r_num   <= {w_digit, {FW{1'b0}}} + {4'd0, r_acc};
          r_rem   <= 4'd0;
          r_cnt   <= '0;
          r_state <= S_DIV;
        end
        S_DIV: begin
          r_num <= {r_num[NW-2:0], w_ge};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(NW - 1)) begin
            r_acc <= w_acc_nxt;
            if (r_k == 3'd0) begin
              r_state <= S_DONE;
            end else begin
              r_k     <= r_k - 3'd1;
              r_state <= S_LOAD;
            end
          end else begin
            r_state <= S_DIV;
          end
        end
        S_DONE: begin
          if (!r_err_pend) begin
            r_z <= r_acc;
          end else begin
            r_z <= r_z;
          end
          r_err   <= r_err_pend;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.oZ    = r_z;
  assign bus.oBusy = r_busy;
  assign bus.oDone = r_done;
  assign bus.oErr  = r_err;

endmodule

// File: tb/tb_dec_to_frac.sv
// Scoreboard bench for dec_to_frac: directed digit vectors push expected
// results; a negedge monitor pops and checks value, error flag and latency.
module tb_dec_to_frac;
  localparam int WZ  = 18;
  localparam int FW  = WZ - 3;
  localparam int LAT = 7 * (FW + 5) + 1;

  typedef struct {
    logic [FW-1:0] z;
    logic          err;
    int            lat;
    int            start;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_vec;
  int   n_err;
  int   n_push;
  int   n_done;
  exp_t sb[$];

  dec_to_frac_if #(.width_z(WZ)) bus ();

  dec_to_frac #(.width_z(WZ), .width_xy(18)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks every oDone against the oldest expectation.
  initial begin : monitor
    exp_t e;
    bit   prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          n_vec++;
          if (bus.oDone) begin
            n_err++;
            $display("FAIL done_pulse: oDone=%0b required 0", bus.oDone);
          end
        end
        prev_done = bus.oDone;
        if (bus.oDone) begin
          n_done++;
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_done: oDone at cycle %0d with no pending request", cyc);
          end else begin
            e = sb.pop_front();
            n_vec++;
            if (bus.oZ !== e.z) begin
              n_err++;
              $display("FAIL oZ: got %0d required %0d", bus.oZ, e.z);
            end
            n_vec++;
            if (bus.oErr !== e.err) begin
              n_err++;
              $display("FAIL oErr: got %0b required %0b", bus.oErr, e.err);
            end
            n_vec++;
            if (cyc - e.start != e.lat) begin
              n_err++;
              $display("FAIL latency: got %0d required %0d", cyc - e.start, e.lat);
            end
          end
        end
      end
    end
  end

  task automatic set_digits(input logic [27:0] dg);
    bus.d0 = dg[27:24];
    bus.d1 = dg[23:20];
    bus.d2 = dg[19:16];
    bus.d3 = dg[15:12];
    bus.d4 = dg[11:8];
    bus.d5 = dg[7:4];
    bus.d6 = dg[3:0];
  endtask

  task automatic start(input logic [27:0] dg, input bit push,
                       input logic [FW-1:0] z, input logic err, input int lat);
    exp_t e;
    @(negedge clk);
    set_digits(dg);
    bus.iStart = 1'b1;
    if (push) begin
      e.z = z;
      e.err = err;
      e.lat = lat;
      e.start = cyc + 1;
      sb.push_back(e);
      n_push++;
    end
    @(negedge clk);
    bus.iStart = 1'b0;
    set_digits(28'h7777777);
  endtask

  task automatic wait_done();
    int bad;
    bit seen;
    bad  = 0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      if (bus.oDone) begin
        seen = 1'b1;
      end else begin
        if (!bus.oBusy) bad++;
        @(negedge clk);
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL timeout: oDone not seen within 400 cycles");
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL busy: oBusy low for %0d cycles required 0", bad);
    end
  endtask

  task automatic conv(input logic [27:0] dg, input logic [FW-1:0] z,
                      input logic err, input int lat);
    start(dg, 1'b1, z, err, lat);
    wait_done();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  initial begin
    cyc    = 0;
    n_vec  = 0;
    n_err  = 0;
    n_push = 0;
    n_done = 0;
    rst_n  = 1'b0;
    bus.iStart = 1'b0;
    set_digits(28'h0000000);
    repeat (3) @(negedge clk);
    chk("reset_oZ", int'(bus.oZ), 0);
    chk("reset_oBusy", int'(bus.oBusy), 0);
    chk("reset_oDone", int'(bus.oDone), 0);
    chk("reset_oErr", int'(bus.oErr), 0);
    rst_n = 1'b1;

    // Abort mid-conversion: no result may appear.
    start(28'h9999999, 1'b0, '0, 1'b0, 0);
    repeat (48) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_oZ", int'(bus.oZ), 0);
    chk("abort_oBusy", int'(bus.oBusy), 0);
    chk("abort_oDone", int'(bus.oDone), 0);
    @(negedge clk);
    rst_n = 1'b1;

    conv(28'h5000000, 15'd16384, 1'b0, LAT);
    conv(28'h2500000, 15'd8192, 1'b0, LAT);
`ifdef DEC_TO_FRAC_ROUND_EN
    conv(28'h1000000, 15'd3277, 1'b0, LAT);
`else
    conv(28'h1000000, 15'd3276, 1'b0, LAT);
`endif
    conv(28'h0000001, 15'd0, 1'b0, LAT);
    conv(28'h9999999, 15'd32767, 1'b0, LAT);
    conv(28'h1234567, 15'd4045, 1'b0, LAT);
    // Invalid digit: fast error, previous oZ retained.
    conv(28'h000A000, 15'd4045, 1'b1, 1);
    conv(28'h5000000, 15'd16384, 1'b0, LAT);

    // Starts while busy and in the done cycle must be ignored.
    start(28'h2500000, 1'b1, 15'd8192, 1'b0, LAT);
    for (int i = 0; i < 10; i++) begin
      repeat (12) @(negedge clk);
      set_digits(28'h9999999);
      bus.iStart = 1'b1;
      @(negedge clk);
      bus.iStart = 1'b0;
    end
    wait_done();
    set_digits(28'h9999999);
    bus.iStart = 1'b1;
    @(negedge clk);
    bus.iStart = 1'b0;
    repeat (170) @(negedge clk);
    chk("done_count", n_done, n_push);
    chk("sb_empty", sb.size(), 0);
    chk("idle_busy", int'(bus.oBusy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
